// File: rtl/rv32_pkg.sv
// Shared RV32I decode definitions: opcodes, ALU operation and immediate format encodings.
package rv32_pkg;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  typedef enum logic [3:0] {
    ALU_ADD   = 4'd0,
    ALU_SUB   = 4'd1,
    ALU_SLL   = 4'd2,
    ALU_SLT   = 4'd3,
    ALU_SLTU  = 4'd4,
    ALU_XOR   = 4'd5,
    ALU_SRL   = 4'd6,
    ALU_SRA   = 4'd7,
    ALU_OR    = 4'd8,
    ALU_AND   = 4'd9,
    ALU_PASSB = 4'd10
  } alu_op_e;

  typedef enum logic [2:0] {
    IMM_I, IMM_S, IMM_B, IMM_U, IMM_J, IMM_NONE
  } imm_type_e;

  function automatic logic [31:0] gen_imm(input imm_type_e t, input logic [31:0] ins);
    case (t)
      IMM_I:   return {{20{ins[31]}}, ins[31:20]};
      IMM_S:   return {{20{ins[31]}}, ins[31:25], ins[11:7]};
      IMM_B:   return {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
      IMM_U:   return {ins[31:12], 12'h000};
      IMM_J:   return {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
      default: return 32'h0;
    endcase
  endfunction

  // alt selects SUB/SRA; the caller decides whether instr[30] is meaningful.
  function automatic alu_op_e alu_from_funct(input logic [2:0] f3, input logic alt);
    case (f3)
      3'd0:    return alt ? ALU_SUB : ALU_ADD;
      3'd1:    return ALU_SLL;
      3'd2:    return ALU_SLT;
      3'd3:    return ALU_SLTU;
      3'd4:    return ALU_XOR;
      3'd5:    return alt ? ALU_SRA : ALU_SRL;
      3'd6:    return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

endpackage

// File: rtl/register_file.sv
// 32-entry architectural register file: two combinational read ports, one clocked write port,
// x0 hardwired to zero, same-cycle write-through bypass to both read ports.
module register_file #(
  parameter int XLEN       = 32,
  parameter int REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic [REG_ADDR_W-1:0] i_rs1_addr,
  input  logic [REG_ADDR_W-1:0] i_rs2_addr,
  output logic [XLEN-1:0]       o_rs1_data,
  output logic [XLEN-1:0]       o_rs2_data,
  input  logic                  i_we,
  input  logic [REG_ADDR_W-1:0] i_wr_addr,
  input  logic [XLEN-1:0]       i_wr_data
);
  localparam int NREGS = 1 << REG_ADDR_W;

  logic [XLEN-1:0] r_regs [NREGS];
  logic            w_wr_en;

  assign w_wr_en = i_we && (i_wr_addr != '0);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < NREGS; i++) r_regs[i] <= '0;
    end else if (w_wr_en) begin
      r_regs[i_wr_addr] <= i_wr_data;
    end
  end

  always_comb begin
    o_rs1_data = r_regs[i_rs1_addr];
    if (i_rs1_addr == '0)                      o_rs1_data = '0;
    else if (w_wr_en && i_wr_addr == i_rs1_addr) o_rs1_data = i_wr_data;
    o_rs2_data = r_regs[i_rs2_addr];
    if (i_rs2_addr == '0)                      o_rs2_data = '0;
    else if (w_wr_en && i_wr_addr == i_rs2_addr) o_rs2_data = i_wr_data;
  end

endmodule

// File: rtl/instruction_decode.sv
// RV32I decode stage: IF/ID register, register file, immediate and control decode, load-use
// stall detection and the ID/EX register. Instruction at edge N reaches id_ex_* after edge N+1.
module instruction_decode #(
  parameter int XLEN       = 32,
  parameter int REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic [XLEN-1:0]       if_pc,
  input  logic [31:0]           if_instr,
  input  logic                  if_valid,
  input  logic                  flush,
  input  logic                  wb_we,
  input  logic [REG_ADDR_W-1:0] wb_rd,
  input  logic [XLEN-1:0]       wb_data,
  output logic                  pc_write,
  output logic                  id_ex_valid,
  output logic [XLEN-1:0]       id_ex_pc,
  output logic [XLEN-1:0]       id_ex_rs1_data,
  output logic [XLEN-1:0]       id_ex_rs2_data,
  output logic [XLEN-1:0]       id_ex_imm,
  output logic [REG_ADDR_W-1:0] id_ex_rs1,
  output logic [REG_ADDR_W-1:0] id_ex_rs2,
  output logic [REG_ADDR_W-1:0] id_ex_rd,
  output logic [2:0]            id_ex_funct3,
  output logic [3:0]            id_ex_alu_op,
  output logic                  id_ex_alu_src,
  output logic                  id_ex_mem_read,
  output logic                  id_ex_mem_write,
  output logic                  id_ex_reg_write,
  output logic                  id_ex_mem_to_reg,
  output logic                  id_ex_branch,
  output logic                  id_ex_jump,
  output logic                  id_ex_illegal
);
  import rv32_pkg::*;

  typedef struct packed {
    logic                  valid;
    logic [XLEN-1:0]       pc;
    logic [XLEN-1:0]       rs1_data;
    logic [XLEN-1:0]       rs2_data;
    logic [XLEN-1:0]       imm;
    logic [REG_ADDR_W-1:0] rs1;
    logic [REG_ADDR_W-1:0] rs2;
    logic [REG_ADDR_W-1:0] rd;
    logic [2:0]            funct3;
    alu_op_e               alu_op;
    logic                  alu_src;
    logic                  mem_read;
    logic                  mem_write;
    logic                  reg_write;
    logic                  mem_to_reg;
    logic                  branch;
    logic                  jump;
    logic                  illegal;
  } idex_t;

  logic                  r_ifid_valid;
  logic [XLEN-1:0]       r_ifid_pc;
  logic [31:0]           r_ifid_instr;
  idex_t                 r_idex;
  idex_t                 w_idex_d;
  imm_type_e             w_imm_type;
  logic                  w_use_rs1;
  logic                  w_use_rs2;
  logic                  w_stall;
  logic                  w_bubble;
  logic [REG_ADDR_W-1:0] w_rs1;
  logic [REG_ADDR_W-1:0] w_rs2;
  logic [XLEN-1:0]       w_rs1_data;
  logic [XLEN-1:0]       w_rs2_data;

  assign w_rs1 = r_ifid_instr[15 +: REG_ADDR_W];
  assign w_rs2 = r_ifid_instr[20 +: REG_ADDR_W];

  register_file #(.XLEN(XLEN), .REG_ADDR_W(REG_ADDR_W)) u_regfile (
    .clk        (clk),
    .resetn     (resetn),
    .i_rs1_addr (w_rs1),
    .i_rs2_addr (w_rs2),
    .o_rs1_data (w_rs1_data),
    .o_rs2_data (w_rs2_data),
    .i_we       (wb_we),
    .i_wr_addr  (wb_rd),
    .i_wr_data  (wb_data)
  );

  always_comb begin
    w_idex_d          = '0;
    w_imm_type        = IMM_NONE;
    w_use_rs1         = 1'b0;
    w_use_rs2         = 1'b0;
    w_idex_d.valid    = 1'b1;
    w_idex_d.pc       = r_ifid_pc;
    w_idex_d.rs1_data = w_rs1_data;
    w_idex_d.rs2_data = w_rs2_data;
    w_idex_d.rs1      = w_rs1;
    w_idex_d.rs2      = w_rs2;
    w_idex_d.rd       = r_ifid_instr[7 +: REG_ADDR_W];
    w_idex_d.funct3   = r_ifid_instr[14:12];
    w_idex_d.alu_op   = ALU_ADD;
    case (r_ifid_instr[6:0])
      OPC_LUI: begin
        w_imm_type = IMM_U; w_idex_d.alu_op = ALU_PASSB;
        w_idex_d.alu_src = 1'b1; w_idex_d.reg_write = 1'b1;
      end
      OPC_AUIPC: begin
        w_imm_type = IMM_U; w_idex_d.alu_src = 1'b1; w_idex_d.reg_write = 1'b1;
      end
      OPC_JAL: begin
        w_imm_type = IMM_J; w_idex_d.alu_src = 1'b1;
        w_idex_d.reg_write = 1'b1; w_idex_d.jump = 1'b1;
      end
      OPC_JALR: begin
        w_imm_type = IMM_I; w_idex_d.alu_src = 1'b1; w_use_rs1 = 1'b1;
        w_idex_d.reg_write = 1'b1; w_idex_d.jump = 1'b1;
      end
      OPC_BRANCH: begin
        w_imm_type = IMM_B; w_idex_d.alu_op = ALU_SUB; w_idex_d.branch = 1'b1;
        w_use_rs1 = 1'b1; w_use_rs2 = 1'b1;
      end
      OPC_LOAD: begin
        w_imm_type = IMM_I; w_idex_d.alu_src = 1'b1; w_use_rs1 = 1'b1;
        w_idex_d.mem_read = 1'b1; w_idex_d.mem_to_reg = 1'b1; w_idex_d.reg_write = 1'b1;
      end
      OPC_STORE: begin
        w_imm_type = IMM_S; w_idex_d.alu_src = 1'b1; w_idex_d.mem_write = 1'b1;
        w_use_rs1 = 1'b1; w_use_rs2 = 1'b1;
      end
      OPC_OP_IMM: begin
        // instr[30] only selects SRAI; for other funct3 it is immediate data
        w_imm_type = IMM_I; w_use_rs1 = 1'b1;
        w_idex_d.alu_op = alu_from_funct(r_ifid_instr[14:12],
                                         (r_ifid_instr[14:12] == 3'd5) && r_ifid_instr[30]);
        w_idex_d.alu_src = 1'b1; w_idex_d.reg_write = 1'b1;
      end
      OPC_OP: begin
        w_use_rs1 = 1'b1; w_use_rs2 = 1'b1;
        w_idex_d.alu_op = alu_from_funct(r_ifid_instr[14:12], r_ifid_instr[30]);
        w_idex_d.reg_write = 1'b1;
      end
      default: w_idex_d.illegal = 1'b1;
    endcase
    w_idex_d.imm = gen_imm(w_imm_type, r_ifid_instr);
    if (w_idex_d.rd == '0) w_idex_d.reg_write = 1'b0;
  end

  assign w_stall  = r_ifid_valid && r_idex.valid && r_idex.mem_read && (r_idex.rd != '0) &&
                    ((w_use_rs1 && w_rs1 == r_idex.rd) || (w_use_rs2 && w_rs2 == r_idex.rd));
  assign w_bubble = flush || w_stall || !r_ifid_valid;
  assign pc_write = flush || !w_stall;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_ifid_valid <= 1'b0;
      r_ifid_pc    <= '0;
      r_ifid_instr <= '0;
    end else if (flush) begin
      r_ifid_valid <= 1'b0;
    end else if (!w_stall) begin
      r_ifid_valid <= if_valid;
      r_ifid_pc    <= if_pc;
      r_ifid_instr <= if_instr;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)       r_idex <= '0;
    else if (w_bubble) r_idex <= '0;
    else               r_idex <= w_idex_d;
  end

  assign id_ex_valid      = r_idex.valid;
  assign id_ex_pc         = r_idex.pc;
  assign id_ex_rs1_data   = r_idex.rs1_data;
  assign id_ex_rs2_data   = r_idex.rs2_data;
  assign id_ex_imm        = r_idex.imm;
  assign id_ex_rs1        = r_idex.rs1;
  assign id_ex_rs2        = r_idex.rs2;
  assign id_ex_rd         = r_idex.rd;
  assign id_ex_funct3     = r_idex.funct3;
  assign id_ex_alu_op     = r_idex.alu_op;
  assign id_ex_alu_src    = r_idex.alu_src;
  assign id_ex_mem_read   = r_idex.mem_read;
  assign id_ex_mem_write  = r_idex.mem_write;
  assign id_ex_reg_write  = r_idex.reg_write;
  assign id_ex_mem_to_reg = r_idex.mem_to_reg;
  assign id_ex_branch     = r_idex.branch;
  assign id_ex_jump       = r_idex.jump;
  assign id_ex_illegal    = r_idex.illegal;

endmodule

// File: tb/tb_instruction_decode.sv
// Scoreboarded bench for instruction_decode: directed cases plus randomized instruction streams
// checked against an instruction-level reference model of the decode stage.
module tb_instruction_decode;

  localparam logic [6:0] M_LUI = 7'h37, M_AUIPC = 7'h17, M_JAL = 7'h6F, M_JALR = 7'h67;
  localparam logic [6:0] M_BR = 7'h63, M_LD = 7'h03, M_ST = 7'h23, M_OPI = 7'h13, M_OP = 7'h33;
  localparam logic [3:0] A_ADD = 4'd0, A_SUB = 4'd1, A_SRA = 4'd7, A_PASSB = 4'd10;

  localparam logic [31:0] I_NOP    = 32'h00000013;
  localparam logic [31:0] I_ADDI   = 32'h00500093;
  localparam logic [31:0] I_ADD311 = 32'h001081B3;
  localparam logic [31:0] I_LW2    = 32'h0000A103;
  localparam logic [31:0] I_LW0    = 32'h0000A003;
  localparam logic [31:0] I_ADD320 = 32'h000101B3;
  localparam logic [31:0] I_ADD300 = 32'h000001B3;
  localparam logic [31:0] I_ADD400 = 32'h00000233;
  localparam logic [31:0] I_ADD655 = 32'h00528333;
  localparam logic [31:0] I_BEQ    = 32'hFE000CE3;
  localparam logic [31:0] I_ILL    = 32'h0000007F;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc, rs1d, rs2d, imm;
    logic [4:0]  rs1, rs2, rd;
    logic [2:0]  f3;
    logic [3:0]  alu_op;
    logic        alu_src, mem_read, mem_write, reg_write, mem_to_reg, branch, jump, illegal;
    logic        pc_write;
  } exp_t;

  logic        clk, resetn;
  logic [31:0] if_pc, if_instr, wb_data;
  logic        if_valid, flush, wb_we;
  logic [4:0]  wb_rd;
  logic        pc_write, id_ex_valid;
  logic [31:0] id_ex_pc, id_ex_rs1_data, id_ex_rs2_data, id_ex_imm;
  logic [4:0]  id_ex_rs1, id_ex_rs2, id_ex_rd;
  logic [2:0]  id_ex_funct3;
  logic [3:0]  id_ex_alu_op;
  logic        id_ex_alu_src, id_ex_mem_read, id_ex_mem_write, id_ex_reg_write;
  logic        id_ex_mem_to_reg, id_ex_branch, id_ex_jump, id_ex_illegal;

  instruction_decode dut (
    .clk(clk), .resetn(resetn), .if_pc(if_pc), .if_instr(if_instr), .if_valid(if_valid),
    .flush(flush), .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data), .pc_write(pc_write),
    .id_ex_valid(id_ex_valid), .id_ex_pc(id_ex_pc), .id_ex_rs1_data(id_ex_rs1_data),
    .id_ex_rs2_data(id_ex_rs2_data), .id_ex_imm(id_ex_imm), .id_ex_rs1(id_ex_rs1),
    .id_ex_rs2(id_ex_rs2), .id_ex_rd(id_ex_rd), .id_ex_funct3(id_ex_funct3),
    .id_ex_alu_op(id_ex_alu_op), .id_ex_alu_src(id_ex_alu_src), .id_ex_mem_read(id_ex_mem_read),
    .id_ex_mem_write(id_ex_mem_write), .id_ex_reg_write(id_ex_reg_write),
    .id_ex_mem_to_reg(id_ex_mem_to_reg), .id_ex_branch(id_ex_branch), .id_ex_jump(id_ex_jump),
    .id_ex_illegal(id_ex_illegal)
  );

  int n_checks = 0;
  int n_errors = 0;
  exp_t q[$];

  logic [31:0] m_regs [32];
  logic        m_ifv;
  logic [31:0] m_ifpc, m_ifins;
  exp_t        m_idex;
  logic        m_pcw;
  logic [3:0]  f3_op [8] = '{4'd0, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd8, 4'd9};
  logic [6:0]  rand_ops [10] = '{M_LUI, M_AUIPC, M_JAL, M_JALR, M_BR, M_LD, M_ST, M_OPI, M_OP, 7'h7F};

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] imm_of(input logic [31:0] ins, input logic [6:0] opc);
    int v;
    v = 0;
    case (opc)
      M_LD, M_OPI, M_JALR: v = int'($signed(ins) >>> 20);
      M_ST: v = (int'($signed(ins) >>> 20) & ~32'h1F) | int'((ins >> 7) & 32'h1F);
      M_BR: v = (ins[31] ? -4096 : 0) + int'((ins >> 7) & 1) * 2048
              + int'((ins >> 25) & 32'h3F) * 32 + int'((ins >> 8) & 32'hF) * 2;
      M_LUI, M_AUIPC: v = int'(ins & 32'hFFFFF000);
      M_JAL: v = (ins[31] ? -(1 << 20) : 0) + int'((ins >> 12) & 32'hFF) * 4096
               + int'((ins >> 20) & 1) * 2048 + int'((ins >> 21) & 32'h3FF) * 2;
      default: v = 0;
    endcase
    return 32'(v);
  endfunction

  function automatic exp_t model_decode(input logic [31:0] pc, input logic [31:0] ins,
                                        input logic [31:0] d1, input logic [31:0] d2);
    exp_t e;
    logic [6:0] opc;
    logic [2:0] f3;
    e = '0;
    opc = ins[6:0];
    f3 = ins[14:12];
    e.valid = 1'b1; e.pc = pc; e.rs1d = d1; e.rs2d = d2;
    e.rs1 = ins[19:15]; e.rs2 = ins[24:20]; e.rd = ins[11:7]; e.f3 = f3;
    e.imm = imm_of(ins, opc);
    e.alu_op = A_ADD;
    case (opc)
      M_LUI:   begin e.alu_op = A_PASSB; e.alu_src = 1; e.reg_write = 1; end
      M_AUIPC: begin e.alu_src = 1; e.reg_write = 1; end
      M_JAL, M_JALR: begin e.alu_src = 1; e.reg_write = 1; e.jump = 1; end
      M_BR:    begin e.alu_op = A_SUB; e.branch = 1; end
      M_LD:    begin e.alu_src = 1; e.mem_read = 1; e.mem_to_reg = 1; e.reg_write = 1; end
      M_ST:    begin e.alu_src = 1; e.mem_write = 1; end
      M_OPI:   begin
        e.alu_op = (f3 == 3'd5 && ins[30]) ? A_SRA : f3_op[f3];
        e.alu_src = 1; e.reg_write = 1;
      end
      M_OP:    begin
        e.alu_op = !ins[30] ? f3_op[f3] : (f3 == 3'd0) ? A_SUB : (f3 == 3'd5) ? A_SRA : f3_op[f3];
        e.reg_write = 1;
      end
      default: e.illegal = 1;
    endcase
    if (e.rd == 5'd0) e.reg_write = 1'b0;
    return e;
  endfunction

  function automatic bit hazard(input logic [31:0] ins, input exp_t ex);
    bit u1, u2;
    u1 = ins[6:0] inside {M_JALR, M_BR, M_LD, M_ST, M_OPI, M_OP};
    u2 = ins[6:0] inside {M_BR, M_ST, M_OP};
    return ex.valid && ex.mem_read && ex.rd != 5'd0 &&
           ((u1 && ins[19:15] == ex.rd) || (u2 && ins[24:20] == ex.rd));
  endfunction

  function automatic logic [31:0] read_reg(input logic [4:0] a, input logic we,
                                           input logic [4:0] wrd, input logic [31:0] wd);
    if (a == 5'd0) return 32'h0;
    if (we && wrd == a) return wd;
    return m_regs[a];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
    m_ifv = 0; m_ifpc = 0; m_ifins = 0; m_idex = '0; m_pcw = 1;
  endtask

  // One clock of stimulus: drive at the falling edge, then predict the state after the next rise.
  task automatic step(input logic v, input logic [31:0] pc, input logic [31:0] ins, input logic fl,
                      input logic we, input logic [4:0] wrd, input logic [31:0] wd);
    exp_t nx;
    bit stall;
    @(negedge clk);
    if_valid = v; if_pc = pc; if_instr = ins; flush = fl; wb_we = we; wb_rd = wrd; wb_data = wd;
    stall = m_ifv && hazard(m_ifins, m_idex);
    if (fl || stall || !m_ifv) nx = '0;
    else nx = model_decode(m_ifpc, m_ifins, read_reg(m_ifins[19:15], we, wrd, wd),
                           read_reg(m_ifins[24:20], we, wrd, wd));
    if (fl) m_ifv = 0;
    else if (!stall) begin m_ifv = v; m_ifpc = pc; m_ifins = ins; end
    if (we && wrd != 5'd0) m_regs[wrd] = wd;
    m_idex = nx;
    nx.pc_write = fl || !(m_ifv && hazard(m_ifins, m_idex));
    m_pcw = nx.pc_write;
    q.push_back(nx);
  endtask

  task automatic idle();
    step(1'b0, 32'h0, I_NOP, 1'b0, 1'b0, 5'd0, 32'h0);
  endtask

  task automatic issue(input logic [31:0] pc, input logic [31:0] ins);
    step(1'b1, pc, ins, 1'b0, 1'b0, 5'd0, 32'h0);
  endtask

  task automatic after_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_valid"}, {31'h0, id_ex_valid}, 32'h0);
    chk({tag, "_pc"}, id_ex_pc, 32'h0);
    chk({tag, "_imm"}, id_ex_imm, 32'h0);
    chk({tag, "_rsdata"}, id_ex_rs1_data | id_ex_rs2_data, 32'h0);
    chk({tag, "_idx"}, {17'h0, id_ex_rs1, id_ex_rs2, id_ex_rd}, 32'h0);
    chk({tag, "_ctrl"}, {17'h0, id_ex_funct3, id_ex_alu_op, id_ex_alu_src, id_ex_mem_read,
        id_ex_mem_write, id_ex_reg_write, id_ex_mem_to_reg, id_ex_branch, id_ex_jump,
        id_ex_illegal}, 32'h0);
    chk({tag, "_pc_write"}, {31'h0, pc_write}, 32'h1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    resetn = 1'b0;
    if_valid = 0; flush = 0; wb_we = 0; wb_rd = 0; wb_data = 0; if_pc = 0; if_instr = 0;
    #1;
    check_reset_outputs("reset");
    model_reset();
    repeat (2) @(negedge clk);
    resetn = 1'b1;
  endtask

  initial begin : monitor
    exp_t act, e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        act = '{valid: id_ex_valid, pc: id_ex_pc, rs1d: id_ex_rs1_data, rs2d: id_ex_rs2_data,
                imm: id_ex_imm, rs1: id_ex_rs1, rs2: id_ex_rs2, rd: id_ex_rd, f3: id_ex_funct3,
                alu_op: id_ex_alu_op, alu_src: id_ex_alu_src, mem_read: id_ex_mem_read,
                mem_write: id_ex_mem_write, reg_write: id_ex_reg_write,
                mem_to_reg: id_ex_mem_to_reg, branch: id_ex_branch, jump: id_ex_jump,
                illegal: id_ex_illegal, pc_write: pc_write};
        n_checks++;
        if (act !== e) begin
          n_errors++;
          $display("FAIL scoreboard at %0t: got %h, expected %h", $time, act, e);
        end
      end
    end
  end

  initial begin : stimulus
    logic        cur_v;
    logic [31:0] cur_pc, cur_ins;
    int          waited;
    resetn = 1'b1;
    if_valid = 0; flush = 0; wb_we = 0; wb_rd = 0; wb_data = 0; if_pc = 0; if_instr = 0;
    do_reset();

    issue(32'h10, I_ADDI);
    issue(32'h14, I_NOP);
    after_edge();
    chk("addi_valid", {31'h0, id_ex_valid}, 32'h1);
    chk("addi_pc", id_ex_pc, 32'h10);
    chk("addi_imm", id_ex_imm, 32'h5);
    chk("addi_rd", {27'h0, id_ex_rd}, 32'h1);
    chk("addi_ctrl", {28'h0, id_ex_alu_src, id_ex_reg_write, id_ex_mem_read, id_ex_branch}, 32'hC);
    chk("addi_alu_op", {28'h0, id_ex_alu_op}, 32'h0);

    issue(32'h18, I_ADD311);
    step(1'b1, 32'h1C, I_NOP, 1'b0, 1'b1, 5'd1, 32'hDEADBEEF);
    after_edge();
    chk("bypass_rs1", id_ex_rs1_data, 32'hDEADBEEF);
    chk("bypass_rs2", id_ex_rs2_data, 32'hDEADBEEF);

    step(1'b1, 32'h20, I_NOP, 1'b0, 1'b1, 5'd5, 32'h0000CAFE);
    issue(32'h24, I_LW2);
    do_reset();
    issue(32'h40, I_ADD655);
    issue(32'h44, I_NOP);
    after_edge();
    chk("x5_after_reset", id_ex_rs1_data, 32'h0);

    issue(32'h50, I_LW2);
    issue(32'h54, I_ADD320);
    after_edge();
    chk("loaduse_hold", {31'h0, pc_write}, 32'h0);
    issue(32'h54, I_ADD320);
    after_edge();
    chk("loaduse_bubble", {30'h0, id_ex_valid, pc_write}, 32'h1);
    issue(32'h58, I_NOP);
    after_edge();
    chk("loaduse_issue", {id_ex_pc[7:0], 3'h0, id_ex_rd, 15'h0, id_ex_valid}, {8'h54, 3'h0, 5'd3, 16'h1});

    issue(32'h60, I_LW0);
    issue(32'h64, I_ADD300);
    after_edge();
    chk("lw_x0_nostall", {31'h0, pc_write}, 32'h1);
    issue(32'h68, I_NOP);
    after_edge();
    chk("lw_x0_issue", {id_ex_pc[7:0], 23'h0, id_ex_valid}, {8'h64, 24'h1});

    issue(32'h70, I_LW2);
    issue(32'h74, I_ADD320);
    step(1'b1, 32'h74, I_ADD320, 1'b1, 1'b0, 5'd0, 32'h0);
    #1;
    chk("flush_pc_write", {31'h0, pc_write}, 32'h1);
    after_edge();
    chk("flush_bubble", {31'h0, id_ex_valid}, 32'h0);
    issue(32'h80, I_NOP);
    after_edge();
    chk("flush_ifid_cleared", {31'h0, id_ex_valid}, 32'h0);

    step(1'b1, 32'h84, I_ADD400, 1'b0, 1'b1, 5'd0, 32'h1234);
    step(1'b1, 32'h88, I_ADD400, 1'b0, 1'b1, 5'd0, 32'h1234);
    after_edge();
    chk("x0_bypass", id_ex_rs1_data, 32'h0);
    issue(32'h8C, I_NOP);
    after_edge();
    chk("x0_read", id_ex_rs1_data, 32'h0);

    issue(32'h90, I_BEQ);
    issue(32'h94, I_NOP);
    after_edge();
    chk("beq_imm", id_ex_imm, 32'hFFFFFFF8);
    chk("beq_branch_f3", {28'h0, id_ex_branch, id_ex_funct3}, 32'h8);

    issue(32'hA0, I_ILL);
    issue(32'hA4, I_NOP);
    after_edge();
    chk("illegal", {29'h0, id_ex_valid, id_ex_illegal, id_ex_reg_write}, 32'h6);

    cur_v = 0; cur_pc = 0; cur_ins = I_NOP;
    for (int n = 0; n < 800; n++) begin
      logic        fl, we;
      logic [4:0]  wrd;
      if (m_pcw) begin
        cur_v = ($urandom_range(0, 9) < 8);
        cur_pc = {$urandom_range(0, 16'hFFFF), 2'b00};
        cur_ins = $urandom;
        cur_ins[6:0] = rand_ops[$urandom_range(0, 9)];
        cur_ins[11:7] = 5'($urandom_range(0, 3));
        cur_ins[19:15] = 5'($urandom_range(0, 3));
        cur_ins[24:20] = 5'($urandom_range(0, 3));
      end
      fl = ($urandom_range(0, 11) == 0);
      we = $urandom_range(0, 1) == 1;
      wrd = 5'($urandom_range(0, 4));
      step(cur_v, cur_pc, cur_ins, fl, we, wrd, $urandom);
    end

    idle();
    idle();
    waited = 0;
    while (q.size() > 0 && waited < 10) begin
      @(posedge clk);
      waited++;
    end
    #2;
    chk("scoreboard_drained", q.size(), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/instruction_decode.md
Name: instruction_decode

Overview:
Decode stage of the pipelined RV32I core. It sits directly downstream of instruction fetch and contains the IF/ID register, the register file, the immediate generator, the control decode, load-use hazard detection, and the ID/EX register. It drives fetch's PC-write enable to stall fetch on a load-use hazard, and accepts a flush from EX on a taken branch or jump.

Parameters:
XLEN, 32, datapath width
REG_ADDR_W, 5, register index width (32 architectural registers)

Ports:
clk  in  1  clock, rising edge
resetn  in  1  asynchronous active-low reset
if_pc  in  XLEN  PC of the instruction on if_instr (aligned by fetch)
if_instr  in  32  fetched instruction
if_valid  in  1  if_pc/if_instr carry a real instruction
flush  in  1  taken branch/jump from EX: squash IF/ID and ID/EX
wb_we  in  1  writeback enable
wb_rd  in  REG_ADDR_W  writeback destination register
wb_data  in  XLEN  writeback data
pc_write  out  1  to fetch pcWrite; 0 = hold PC
id_ex_valid  out  1  ID/EX holds a real instruction
id_ex_pc  out  XLEN  PC of the instruction
id_ex_rs1_data, id_ex_rs2_data  out  XLEN each  operand values
id_ex_imm  out  XLEN  sign-extended immediate
id_ex_rs1, id_ex_rs2, id_ex_rd  out  REG_ADDR_W each  register indices (for forwarding)
id_ex_funct3  out  3  instr[14:12]
id_ex_alu_op  out  4  alu_op_e encoding
id_ex_alu_src  out  1  1 = second ALU operand is imm
id_ex_mem_read, id_ex_mem_write, id_ex_reg_write, id_ex_mem_to_reg, id_ex_branch, id_ex_jump  out  1 each  control bits
id_ex_illegal  out  1  unknown opcode

Behaviour:
- Reset is asynchronous and active-low. All flops clear: IF/ID valid=0, every ID/EX output=0, all 32 registers=0. pc_write=1, because it is combinational from id_ex_valid=0. Reset asserted mid-operation discards all in-flight state at once.
- Latency: an instruction presented at edge N is captured in IF/ID at N and appears on the id_ex_* outputs after edge N+1.
- IF/ID register:
  - flush=1: valid cleared.
  - stall: holds.
  - otherwise: captures if_pc, if_instr and if_valid.
- Register file: 2 combinational read ports, 1 write port on the clk edge.
  - Reads of x0 return 0. Writes to x0 are ignored.
  - Write-through bypass: if wb_we, wb_rd==rsN and wb_rd!=0, the read returns wb_data in the same cycle.
- Immediate formats, sign-extended from instr[31]:
  - I: LOAD, OP-IMM, JALR
  - S: STORE
  - B: BRANCH, bit0=0
  - U: LUI, AUIPC, low 12 bits=0
  - J: JAL, bit0=0
  - OP: imm=0
- Control decode by opcode: LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OP-IMM, OP.
  - Any other opcode sets illegal=1, all write/memory controls=0, and valid is kept.
  - reg_write is forced 0 when rd==0.
- rs usage:
  - rs1 is used by JALR, BRANCH, LOAD, STORE, OP-IMM, OP.
  - rs2 is used by BRANCH, STORE, OP.
- Load-use stall = IF/ID valid && id_ex_valid && id_ex_mem_read && id_ex_rd!=0 && id_ex_rd matches a used rs of the IF/ID instruction. On stall:
  - pc_write=0
  - IF/ID holds
  - ID/EX loads a bubble: valid=0, all controls 0
- flush has priority over stall: IF/ID is cleared, ID/EX gets a bubble, pc_write=1.
- An invalid IF/ID entry yields a bubble in ID/EX and never causes a stall.

Decomposition:
- Package rv32_pkg holds:
  - the opcode constants
  - alu_op_e (4-bit: ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND, PASSB)
  - imm_type_e (I, S, B, U, J, NONE)
- One sub-module, register_file: 32xXLEN, async reset, x0 hardwired to zero, write-through bypass.

Test Plan:
- Reset: drive resetn=0 mid-stream -> all id_ex_* outputs 0 and pc_write=1 immediately; after release, reading x5 returns 0.
- ADDI x1,x0,5 (0x00500093), if_pc=0x10 -> two edges later: id_ex_valid=1, pc=0x10, imm=5, rd=1, alu_src=1, reg_write=1, alu_op=ADD.
- Bypass: wb_we=1, wb_rd=1, wb_data=0xDEADBEEF while IF/ID holds ADD x3,x1,x1 -> rs1_data=rs2_data=0xDEADBEEF.
- Load-use: LW x2,0(x1) then ADD x3,x2,x0 -> exactly one cycle with pc_write=0 and a bubble (id_ex_valid=0), then ADD issues. The same sequence with LW x0 -> no stall.
- Flush during a stall -> pc_write=1, IF/ID invalid, id_ex_valid=0 next cycle. Write x0=0x1234 -> a later read of x0 returns 0.
- BEQ x0,x0,-8 (0xFE000CE3) -> id_ex_imm=0xFFFFFFF8, branch=1, funct3=0. Opcode 0x7F -> illegal=1, reg_write=0.
